// File: rtl/frac_dpram_tile.sv
// Fracturable simple dual-port RAM tile: one write port, one read port, one clock.
// Word width is DATA_WIDTH>>cfg_mode; an optional second output stage adds a cycle of latency.
module frac_dpram_tile #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned LOG_DW     = $clog2(DATA_WIDTH),
   parameter int unsigned MODE_WIDTH = $clog2(LOG_DW + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [MODE_WIDTH-1:0]        cfg_mode,
   input  logic                         cfg_out_reg,
   input  logic                         wen,
   input  logic [ADDR_WIDTH+LOG_DW-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         ren,
   input  logic [ADDR_WIDTH+LOG_DW-1:0] raddr,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         rvalid
);

   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned NMODES = 2 ** MODE_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [NMODES-1:0]     mode_legal;
   logic                  mode_ok;
   logic [DATA_WIDTH-1:0] word_ones;
   logic [MODE_WIDTH-1:0] narrow_sh;
   logic [LOG_DW-1:0]     lane_mask;
   logic [ADDR_WIDTH-1:0] w_row;
   logic [ADDR_WIDTH-1:0] r_row;
   logic [LOG_DW-1:0]     w_off;
   logic [LOG_DW-1:0]     r_off;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  we;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rd_d, rd_q;
   logic                  s1_valid_d, s1_valid_q;
   logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;
   logic                  s2_valid_d, s2_valid_q;

   // Address split and lane placement; lane L sits at bit offset L*W = L << (LOG_DW-m).
   always_comb begin
      mode_legal = '0;
      for (int unsigned i = 0; i < NMODES; i++) begin
         mode_legal[i] = (i <= LOG_DW);
      end
      mode_ok   = mode_legal[cfg_mode];
      word_ones = ~({DATA_WIDTH{1'b1}} << (DATA_WIDTH >> cfg_mode));
      narrow_sh = MODE_WIDTH'(LOG_DW) - cfg_mode;
      lane_mask = ~({LOG_DW{1'b1}} << cfg_mode);
      w_row     = ADDR_WIDTH'(waddr >> cfg_mode);
      r_row     = ADDR_WIDTH'(raddr >> cfg_mode);
      w_off     = (waddr[LOG_DW-1:0] & lane_mask) << narrow_sh;
      r_off     = (raddr[LOG_DW-1:0] & lane_mask) << narrow_sh;
      wmask     = word_ones << w_off;
      wdata     = (data_in & word_ones) << w_off;
      we        = wen & mode_ok;
      rd_word   = mode_ok ? ((mem_q[r_row] >> r_off) & word_ones) : '0;
   end

   // Read stage 1 captures the extracted lane; stage 2 always follows stage 1.
   always_comb begin
      rd_d       = rd_q;
      s1_valid_d = ren;
      s2_data_d  = rd_q;
      s2_valid_d = s1_valid_q;
      if (ren) begin
         rd_d = rd_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_valid_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         s1_valid_q <= s1_valid_d;
         s2_data_q  <= s2_data_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // Storage is never reset; per-bit enables leave the other lanes of the row untouched.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            if (wmask[b]) begin
               mem_q[w_row][b] <= wdata[b];
            end
         end
      end
   end

   always_comb begin
      data_out = cfg_out_reg ? s2_data_q  : rd_q;
      rvalid   = cfg_out_reg ? s2_valid_q : s1_valid_q;
   end

endmodule

// File: tb/tb_frac_dpram_tile.sv
// Randomized and directed bench for frac_dpram_tile against a word-level memory model.
module tb_frac_dpram_tile;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  cfg_mode;
   logic        cfg_out_reg;
   logic        wen, ren;
   logic [11:0] waddr, raddr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        rvalid;

   logic        r4;
   logic [1:0]  m4;
   logic        wen4, ren4;
   logic [3:0]  waddr4, raddr4;
   logic [3:0]  din4, dout4;
   logic        rv4;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] ref_mem [512];
   int         cur_mode, cur_oreg;
   logic [7:0] m_rd, m_s2d;
   logic       m_s1v, m_s2v;

   always #5 clk = ~clk;

   frac_dpram_tile dut (
      .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_out_reg(cfg_out_reg),
      .wen(wen), .waddr(waddr), .data_in(data_in), .ren(ren), .raddr(raddr),
      .data_out(data_out), .rvalid(rvalid)
   );

   frac_dpram_tile #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut4 (
      .clk(clk), .reset(r4), .cfg_mode(m4), .cfg_out_reg(1'b0),
      .wen(wen4), .waddr(waddr4), .data_in(din4), .ren(ren4), .raddr(raddr4),
      .data_out(dout4), .rvalid(rv4)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input int m, input logic [11:0] a);
      int w    = 8 >> m;
      int row  = (int'(a) >> m) % 512;
      int lane = int'(a) % (1 << m);
      return 8'((int'(ref_mem[row]) >> (lane * w)) % (1 << w));
   endfunction

   task automatic model_write(input int m, input logic [11:0] a, input logic [7:0] d);
      int w    = 8 >> m;
      int row  = (int'(a) >> m) % 512;
      int lane = int'(a) % (1 << m);
      for (int b = 0; b < w; b++) ref_mem[row][lane * w + b] = d[b];
   endtask

   task automatic drive(input logic w, input logic [11:0] wa, input logic [7:0] d,
                        input logic r, input logic [11:0] ra);
      wen = w; waddr = wa; data_in = d; ren = r; raddr = ra;
   endtask

   // One clock: advance the model with the driven inputs, then compare outputs at the falling edge.
   task automatic tick();
      m_s2d = m_rd;
      m_s2v = m_s1v;
      if (ren) m_rd = model_read(cur_mode, raddr);
      m_s1v = ren;
      if (wen) model_write(cur_mode, waddr, data_in);
      @(posedge clk);
      @(negedge clk);
      check_eq("dout",   32'(data_out), 32'(cur_oreg != 0 ? m_s2d : m_rd));
      check_eq("rvalid", 32'(rvalid),   32'(cur_oreg != 0 ? m_s2v : m_s1v));
   endtask

   // Called at a falling edge: assert reset, check the immediate clear, reconfigure, release.
   task automatic apply_reset(input int m, input int oreg);
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
      reset = 1'b1;
      #1;
      m_rd = 8'h0; m_s2d = 8'h0; m_s1v = 1'b0; m_s2v = 1'b0;
      check_eq("rst_dout",   32'(data_out), 32'h0);
      check_eq("rst_rvalid", 32'(rvalid),   32'h0);
      cur_mode    = m;
      cur_oreg    = oreg;
      cfg_mode    = 2'(m);
      cfg_out_reg = oreg[0];
      #2;
      reset = 1'b0;
   endtask

   task automatic tick4();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; cfg_mode = 2'd0; cfg_out_reg = 1'b0;
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);
      r4 = 1'b1; m4 = 2'd0; wen4 = 1'b0; ren4 = 1'b0;
      waddr4 = 4'h0; raddr4 = 4'h0; din4 = 4'h0;
      m_rd = 8'h0; m_s2d = 8'h0; m_s1v = 1'b0; m_s2v = 1'b0;
      @(negedge clk);
      apply_reset(0, 0);

      for (int i = 0; i < 512; i++) begin
         drive(1'b1, 12'(i), 8'($urandom), 1'b0, 12'h0);
         tick();
      end

      // Basic mode 0 write then read, 1-cycle latency
      drive(1'b1, 12'h003, 8'hA5, 1'b0, 12'h0); tick();
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h003);  tick();
      check_eq("m0_data", 32'(data_out), 32'hA5);
      check_eq("m0_rv",   32'(rvalid),   32'h1);
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);    tick();
      check_eq("m0_hold", 32'(data_out), 32'hA5);
      check_eq("m0_rv0",  32'(rvalid),   32'h0);

      // Mode 2 lane write into a cleared row
      drive(1'b1, 12'h003, 8'h00, 1'b0, 12'h0); tick();
      @(negedge clk);
      apply_reset(2, 0);
      drive(1'b1, 12'h00D, 8'hFF, 1'b0, 12'h0); tick();
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h00D);  tick();
      check_eq("m2_lane1", 32'(data_out), 32'h03);
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h00C);  tick();
      check_eq("m2_lane0", 32'(data_out), 32'h00);
      apply_reset(0, 0);
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h003);  tick();
      check_eq("m2_row", 32'(data_out), 32'h0C);

      // Mode 3 with output register, then a 4-read stream
      apply_reset(3, 1);
      drive(1'b1, 12'hFFF, 8'h01, 1'b0, 12'h0); tick();
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'hFFF);  tick();
      check_eq("m3_rv_early", 32'(rvalid), 32'h0);
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);    tick();
      check_eq("m3_data", 32'(data_out), 32'h01);
      check_eq("m3_rv",   32'(rvalid),   32'h1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 12'h0, 8'h0, i < 4, 12'hFF8 + 12'(i));
         tick();
         pulses += int'(rvalid);
      end
      check_eq("stream_pulses", 32'(pulses), 32'd4);

      // Read-during-write to the same row returns old contents
      apply_reset(0, 0);
      drive(1'b1, 12'h005, 8'h11, 1'b0, 12'h0); tick();
      drive(1'b1, 12'h005, 8'h22, 1'b1, 12'h005); tick();
      check_eq("rdw_old", 32'(data_out), 32'h11);
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h005);  tick();
      check_eq("rdw_new", 32'(data_out), 32'h22);

      // Reset while a read is in flight through the output stage
      apply_reset(0, 1);
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h005);  tick();
      apply_reset(0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("no_ghost_rv", 32'(rvalid), 32'h0);
      end
      drive(1'b0, 12'h0, 8'h0, 1'b1, 12'h005);  tick();
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);    tick();
      check_eq("row5_kept", 32'(data_out), 32'h22);

      // Randomized traffic over every mode and both latency settings
      for (int p = 0; p < 8; p++) begin
         apply_reset(p % 4, p / 4);
         for (int i = 0; i < 150; i++) begin
            logic [11:0] wa;
            wa = 12'($urandom);
            drive(1'($urandom), wa, 8'($urandom), ($urandom % 4) != 0,
                  (($urandom % 3) == 0) ? wa : 12'($urandom));
            tick();
         end
      end
      drive(1'b0, 12'h0, 8'h0, 1'b0, 12'h0);

      // Illegal mode on a 4-bit tile
      r4 = 1'b0;
      wen4 = 1'b1; waddr4 = 4'h0; din4 = 4'h9; tick4();
      wen4 = 1'b0; ren4 = 1'b1; raddr4 = 4'h0; tick4();
      check_eq("w4_legal", 32'(dout4), 32'h9);
      ren4 = 1'b0;
      r4 = 1'b1; m4 = 2'd3; #2; r4 = 1'b0;
      wen4 = 1'b1; waddr4 = 4'h0; din4 = 4'h6; tick4();
      wen4 = 1'b0; ren4 = 1'b1; raddr4 = 4'h0; tick4();
      check_eq("ill_rv",   32'(rv4),   32'h1);
      check_eq("ill_data", 32'(dout4), 32'h0);
      ren4 = 1'b0;
      r4 = 1'b1; m4 = 2'd0; #2; r4 = 1'b0;
      ren4 = 1'b1; raddr4 = 4'h0; tick4();
      check_eq("ill_nowrite", 32'(dout4), 32'h9);
      ren4 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/frac_dpram_tile.md
Name: frac_dpram_tile

Overview:
- Parametrised successor to the fixed 512x8 memory grid primitive.
- Simple dual-port synchronous RAM: one write port, one read port, one clock.
- Fracturable aspect ratio is selected by static configuration bits: full width DATA_WIDTH, or DATA_WIDTH>>m with 2^m times the depth.
- Optional output pipeline register and a read-valid flag.
- Instantiated as the logical tile inside the next-generation memory grid; configuration ports are driven by the fabric configuration chain.

Parameters:
- DATA_WIDTH, 8: physical row width; power of two, at least 1.
- ADDR_WIDTH, 9: physical row address bits; depth is 2^ADDR_WIDTH rows.
- LOG_DW, $clog2(DATA_WIDTH) = 3: number of narrowing steps.
- MODE_WIDTH, $clog2(LOG_DW+1) = 2: width of the mode configuration input.

Ports:
- clk  in  1  user clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers except the storage array.
- cfg_mode  in  MODE_WIDTH  aspect mode m; word width W = DATA_WIDTH>>m; static during operation.
- cfg_out_reg  in  1  1 = extra output pipeline stage.
- wen  in  1  write enable.
- waddr  in  ADDR_WIDTH+LOG_DW  word address; the upper bits are ignored per mode.
- data_in  in  DATA_WIDTH  write data; only bits [W-1:0] are used.
- ren  in  1  read enable.
- raddr  in  ADDR_WIDTH+LOG_DW  word address.
- data_out  out  DATA_WIDTH  read data, zero-extended above bit W-1.
- rvalid  out  1  pulses with each data_out update caused by ren.

Behaviour:
- Address split for mode m:
  - row = addr[ADDR_WIDTH+m-1 : m]
  - lane = addr[m-1:0] (none when m=0)
  - addr bits above ADDR_WIDTH+m-1 are ignored.
  - Lane L occupies row bits [L*W+W-1 : L*W].
- Write: on a clk edge with wen=1, row bits of lane L take data_in[W-1:0]. Other lanes of that row are unchanged, so a bit-mask write is required with no read-modify-write cycle.
- Read stage 1: on a clk edge with ren=1, the row is read and the lane index is captured. Lane extraction and zero-extension produce rd_q; s1_valid is set to 1. With ren=0, rd_q holds its value and s1_valid=0.
- Latency:
  - cfg_out_reg=0: data_out = rd_q and rvalid = s1_valid, so data appears 1 cycle after ren is sampled.
  - cfg_out_reg=1: a second register stage always loads rd_q/s1_valid; data_out and rvalid come from that stage, giving 2 cycles.
- Hold: data_out keeps its last value while no new read propagates. rvalid is a single-cycle pulse per read.
- Read-during-write:
  - Same row, same edge: the read returns pre-write (old) contents for all lanes (read-first).
  - Different rows: the two ports are independent.
- Back-to-back reads every cycle are supported at full throughput in both latency settings.
- Illegal mode (cfg_mode > LOG_DW):
  - Writes are suppressed; the array is unchanged.
  - Reads still pulse rvalid, but data_out = 0.
- Reset:
  - Asserting reset (asynchronous) forces rd_q, the stage-2 data, data_out, s1_valid, the stage-2 valid and rvalid to 0 immediately.
  - Array contents are preserved.
  - A read in flight during reset is dropped; no rvalid is produced for it after release.
  - The first edge after deassertion behaves normally.
- Config change: cfg_mode and cfg_out_reg are sampled combinationally. Changing them mid-operation is unsupported; the bench only changes them while reset=1.
- Array: register-based (reg array) for synthesis portability; no initial contents are assumed and reads of unwritten rows are X in simulation.

Test Plan:
- Mode 0, cfg_out_reg=0: write 0xA5 to addr 0x003, then ren raddr 0x003 on the next cycle -> data_out=0xA5 and rvalid=1 exactly 1 cycle later; rvalid=0 the following cycle, with data_out held.
- Mode 2 (W=2): write 2'b11 to addr 0x00D (row 3, lane 1), having previously written row 3 = 0x00 in mode 0 under a reset-only config change -> read addr 0x00D gives 0x03, read addr 0x00C gives 0x00; a mode 0 read of row 3 gives 0x0C.
- Mode 3 (W=1), cfg_out_reg=1: write 1 to addr 0xFFF -> read gives data_out=0x01 with rvalid 2 cycles after ren; a continuous ren stream over 4 addresses gives 4 consecutive rvalid pulses.
- Collision: row 5 = 0x11, then in the same cycle wen addr 5 data 0x22 and ren addr 5 -> data_out=0x11; the next read gives 0x22.
- Reset mid-read: ren at cycle N, reset asserted between edges N and N+1 -> data_out=0 and rvalid=0 immediately, with no rvalid after release; previously written row 5 still reads 0x22.
- Illegal mode: with DATA_WIDTH=4 (LOG_DW=2, MODE_WIDTH=2), cfg_mode=3 and a write attempt to row 0 -> array unchanged, read pulses rvalid with data_out=0.
